// File: rtl/tester_ctrl_fsm_if.sv
// Handshake/bus bundle between the tester control FSM and its surroundings
// (uart_rx/uart_tx, channel state memory, button debouncers).
// slave: the control FSM's view. master: the environment's view.
interface tester_ctrl_fsm_if #(
    parameter int unsigned DATA_W = 6,
    parameter int unsigned NUM_CH = 4
);
    localparam int unsigned ADDR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              in_push_sw;
    logic [ADDR_W-1:0] in_sw_ch;
    logic              in_push_rst;
    logic              in_urx_vld;
    logic [7:0]        in_urx;
    logic [DATA_W-1:0] in_mem;
    logic              in_mem_w_rd;
    logic              in_utx_s_bs;
    logic              in_utx_s_rd;
    logic [ADDR_W-1:0] out_mem_addr;
    logic [DATA_W-1:0] out_mem;
    logic              out_mem_w_en;
    logic [7:0]        out_utx;
    logic              out_utx_s_en;
    logic              out_rst;
    logic              out_busy;
    logic              out_err;

    modport slave (
        input  in_push_sw, in_sw_ch, in_push_rst, in_urx_vld, in_urx,
               in_mem, in_mem_w_rd, in_utx_s_bs, in_utx_s_rd,
        output out_mem_addr, out_mem, out_mem_w_en, out_utx, out_utx_s_en,
               out_rst, out_busy, out_err
    );

    modport master (
        output in_push_sw, in_sw_ch, in_push_rst, in_urx_vld, in_urx,
               in_mem, in_mem_w_rd, in_utx_s_bs, in_utx_s_rd,
        input  out_mem_addr, out_mem, out_mem_w_en, out_utx, out_utx_s_en,
               out_rst, out_busy, out_err
    );
endinterface

// File: rtl/tester_ctrl_fsm.sv
// Tester control FSM: arbitrates push buttons and UART commands, drives the
// multi-channel state memory and echoes channel status over UART.
// Optional handshake timeout: define TESTER_FSM_TIMEOUT_EN.
module tester_ctrl_fsm #(
    parameter int unsigned DATA_W      = 6,
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input logic              in_clk,
    input logic              in_rst,
    tester_ctrl_fsm_if.slave bus
);
    localparam int unsigned ADDR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [DATA_W-1:0] MSB_MASK = DATA_W'(1) << (DATA_W - 1);

    typedef enum logic [2:0] {
        StIdle, StRxData, StRd, StWrite, StReset, StWait, StSend
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_w_en_q;
    logic [7:0]        utx_q;
    logic              utx_s_en_q;
    logic              rst_q;
    logic              busy_q;
    logic              err_q;
    logic              all_q;   // all-channel dump in progress
    logic              tgl_q;   // next RD belongs to a button toggle
    logic              pend_q;  // reset request waiting for IDLE

    logic [1:0]        hdr_op;
    logic [5:0]        hdr_ch;
    logic              hdr_ch_ok;
    logic              hdr_all;
    logic              waiting;
    logic              progress;
    logic              tmo_hit;

    assign hdr_op    = bus.in_urx[7:6];
    assign hdr_ch    = bus.in_urx[5:0];
    assign hdr_ch_ok = 32'(hdr_ch) < NUM_CH;
    assign hdr_all   = (hdr_ch == 6'h3F);

    // States that block on an external handshake, and the event releasing each.
    assign waiting  = (state_q == StRxData) || (state_q == StWrite) ||
                      (state_q == StWait)   || (state_q == StSend);
    assign progress = ((state_q == StRxData) && bus.in_urx_vld)  ||
                      ((state_q == StWrite)  && bus.in_mem_w_rd) ||
                      ((state_q == StWait)   && !bus.in_utx_s_bs) ||
                      ((state_q == StSend)   && bus.in_utx_s_rd);

`ifdef TESTER_FSM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] tmo_cnt_q;

    assign tmo_hit = waiting && !progress && (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Count stalled cycles in a handshake state; any state change restarts it.
    always_ff @(posedge in_clk) begin
        if (in_rst || !waiting || progress || tmo_hit) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYC;
    assign tmo_hit    = 1'b0;
`endif

    // Main controller: state, datapath registers and all registered outputs.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            mem_wdata_q <= '0;
            mem_w_en_q  <= 1'b0;
            utx_q       <= '0;
            utx_s_en_q  <= 1'b0;
            rst_q       <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            all_q       <= 1'b0;
            tgl_q       <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            rst_q <= 1'b0;
            err_q <= 1'b0;
            // Reset requests arriving while busy are parked until IDLE.
            if (bus.in_push_rst && (state_q != StIdle) && (state_q != StReset)) begin
                pend_q <= 1'b1;
            end
            if (tmo_hit) begin
                state_q    <= StIdle;
                busy_q     <= 1'b0;
                err_q      <= 1'b1;
                mem_w_en_q <= 1'b0;
                utx_s_en_q <= 1'b0;
                all_q      <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (pend_q) begin
                            state_q <= StReset;
                            rst_q   <= 1'b1;
                            busy_q  <= 1'b1;
                        end else if (bus.in_push_sw) begin
                            addr_q  <= bus.in_sw_ch;
                            tgl_q   <= 1'b1;
                            all_q   <= 1'b0;
                            state_q <= StRd;
                            busy_q  <= 1'b1;
                            pend_q  <= bus.in_push_rst;
                        end else if (bus.in_urx_vld && (hdr_op != 2'b00)) begin
                            if (hdr_op != 2'b11) begin
                                pend_q <= bus.in_push_rst;
                            end
                            unique case (hdr_op)
                                2'b01: begin
                                    if (hdr_all) begin
                                        addr_q  <= '0;
                                        all_q   <= 1'b1;
                                        tgl_q   <= 1'b0;
                                        state_q <= StRd;
                                        busy_q  <= 1'b1;
                                    end else if (hdr_ch_ok) begin
                                        addr_q  <= ADDR_W'(hdr_ch);
                                        all_q   <= 1'b0;
                                        tgl_q   <= 1'b0;
                                        state_q <= StRd;
                                        busy_q  <= 1'b1;
                                    end else begin
                                        err_q <= 1'b1;
                                    end
                                end
                                2'b10: begin
                                    if (hdr_ch_ok) begin
                                        addr_q  <= ADDR_W'(hdr_ch);
                                        all_q   <= 1'b0;
                                        tgl_q   <= 1'b0;
                                        state_q <= StRxData;
                                        busy_q  <= 1'b1;
                                    end else begin
                                        err_q <= 1'b1;
                                    end
                                end
                                default: begin
                                    state_q <= StReset;
                                    rst_q   <= 1'b1;
                                    busy_q  <= 1'b1;
                                end
                            endcase
                        end else if (bus.in_push_rst) begin
                            state_q <= StReset;
                            rst_q   <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                    StRxData: begin
                        if (bus.in_urx_vld) begin
                            mem_wdata_q <= bus.in_urx[DATA_W-1:0];
                            mem_w_en_q  <= 1'b1;
                            state_q     <= StWrite;
                        end
                    end
                    StRd: begin
                        if (tgl_q) begin
                            mem_wdata_q <= bus.in_mem ^ MSB_MASK;
                            mem_w_en_q  <= 1'b1;
                            tgl_q       <= 1'b0;
                            state_q     <= StWrite;
                        end else begin
                            utx_q      <= 8'(bus.in_mem);
                            utx_s_en_q <= 1'b1;
                            state_q    <= StWait;
                        end
                    end
                    StWrite: begin
                        // Re-read after the write so the new value is echoed.
                        if (bus.in_mem_w_rd) begin
                            mem_w_en_q <= 1'b0;
                            state_q    <= StRd;
                        end
                    end
                    StReset: begin
                        pend_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                    StWait: begin
                        if (!bus.in_utx_s_bs) begin
                            state_q <= StSend;
                        end
                    end
                    StSend: begin
                        if (bus.in_utx_s_rd) begin
                            utx_s_en_q <= 1'b0;
                            if (all_q && (32'(addr_q) < NUM_CH - 1)) begin
                                addr_q  <= addr_q + ADDR_W'(1);
                                state_q <= StRd;
                            end else begin
                                all_q   <= 1'b0;
                                busy_q  <= 1'b0;
                                state_q <= StIdle;
                            end
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.out_mem_addr = addr_q;
    assign bus.out_mem      = mem_wdata_q;
    assign bus.out_mem_w_en = mem_w_en_q;
    assign bus.out_utx      = utx_q;
    assign bus.out_utx_s_en = utx_s_en_q;
    assign bus.out_rst      = rst_q;
    assign bus.out_busy     = busy_q;
    assign bus.out_err      = err_q;
endmodule

// File: tb/tb_tester_ctrl_fsm.sv
// Directed bench for tester_ctrl_fsm (NUM_CH=4, DATA_W=6, TIMEOUT_CYC=16).
module tb_tester_ctrl_fsm;
    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [5:0] mem [4];

    tester_ctrl_fsm_if #(.DATA_W(6), .NUM_CH(4)) bus ();

    tester_ctrl_fsm #(.DATA_W(6), .NUM_CH(4), .TIMEOUT_CYC(16)) dut (
        .in_clk (clk),
        .in_rst (rst),
        .bus    (bus)
    );

    // Memory model: combinational read of the addressed word.
    assign bus.in_mem = mem[bus.out_mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    // Completes one memory write once out_mem_w_en appears (bounded).
    task automatic wait_write(output logic [1:0] a, output logic [5:0] d, output bit ok);
        ok = 1'b0;
        a  = '0;
        d  = '0;
        for (int i = 0; i < 20; i++) begin
            if (!ok) begin
                if (bus.out_mem_w_en) begin
                    a = bus.out_mem_addr;
                    d = bus.out_mem;
                    mem[a] = d;
                    bus.in_mem_w_rd = 1'b1;
                    tick();
                    bus.in_mem_w_rd = 1'b0;
                    ok = 1'b1;
                end else begin
                    tick();
                end
            end
        end
    endtask

    // Completes one UART send once out_utx_s_en appears (bounded, tx idle).
    task automatic wait_send(output logic [7:0] b, output bit ok);
        ok = 1'b0;
        b  = '0;
        for (int i = 0; i < 20; i++) begin
            if (!ok) begin
                if (bus.out_utx_s_en) begin
                    b = bus.out_utx;
                    tick();
                    bus.in_utx_s_rd = 1'b1;
                    tick();
                    bus.in_utx_s_rd = 1'b0;
                    ok = 1'b1;
                end else begin
                    tick();
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks += 8;
        if (bus.out_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.out_busy); end
        if (bus.out_mem_w_en !== 1'b0) begin errors++; $display("FAIL reset_w_en: got %b want 0", bus.out_mem_w_en); end
        if (bus.out_utx_s_en !== 1'b0) begin errors++; $display("FAIL reset_s_en: got %b want 0", bus.out_utx_s_en); end
        if (bus.out_rst !== 1'b0) begin errors++; $display("FAIL reset_rst: got %b want 0", bus.out_rst); end
        if (bus.out_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.out_err); end
        if (bus.out_mem_addr !== 2'd0) begin errors++; $display("FAIL reset_addr: got %0h want 0", bus.out_mem_addr); end
        if (bus.out_mem !== 6'h00) begin errors++; $display("FAIL reset_mem: got %0h want 0", bus.out_mem); end
        if (bus.out_utx !== 8'h00) begin errors++; $display("FAIL reset_utx: got %0h want 0", bus.out_utx); end
        tick();
        checks++;
        if (bus.out_busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy got %b want 0", bus.out_busy); end
    endtask

    task automatic test_toggle();
        logic [1:0] a;
        logic [5:0] d;
        logic [7:0] b;
        bit         ok;
        mem[2] = 6'h05;
        bus.in_sw_ch   = 2'd2;
        bus.in_push_sw = 1'b1;
        tick();
        bus.in_push_sw = 1'b0;
        checks++;
        if (bus.out_busy !== 1'b1 || bus.out_mem_w_en !== 1'b0) begin
            errors++;
            $display("FAIL toggle_rd: busy=%b w_en=%b want busy=1 w_en=0", bus.out_busy, bus.out_mem_w_en);
        end
        tick();
        checks++;
        if (bus.out_mem_w_en !== 1'b1 || bus.out_mem_addr !== 2'd2 || bus.out_mem !== 6'h25) begin
            errors++;
            $display("FAIL toggle_write: w_en=%b addr=%0h data=%0h want 1/2/25",
                     bus.out_mem_w_en, bus.out_mem_addr, bus.out_mem);
        end
        wait_write(a, d, ok);
        checks++;
        if (!ok || a !== 2'd2 || d !== 6'h25) begin
            errors++;
            $display("FAIL toggle_wr_done: ok=%b addr=%0h data=%0h want 1/2/25", ok, a, d);
        end
        wait_send(b, ok);
        checks++;
        if (!ok || b !== 8'h25) begin errors++; $display("FAIL toggle_echo: ok=%b got %0h want 25", ok, b); end
        checks++;
        if (bus.out_busy !== 1'b0 || bus.out_utx_s_en !== 1'b0) begin
            errors++;
            $display("FAIL toggle_idle: busy=%b s_en=%b want 0/0", bus.out_busy, bus.out_utx_s_en);
        end
    endtask

    task automatic test_setup();
        logic [1:0] a;
        logic [5:0] d;
        logic [7:0] b;
        bit         ok;
        bus.in_urx = 8'h81; bus.in_urx_vld = 1'b1;
        tick();
        bus.in_urx_vld = 1'b0;
        tick();
        tick();
        bus.in_urx = 8'h1A; bus.in_urx_vld = 1'b1;
        tick();
        bus.in_urx_vld = 1'b0;
        wait_write(a, d, ok);
        checks++;
        if (!ok || a !== 2'd1 || d !== 6'h1A) begin
            errors++;
            $display("FAIL setup_write: ok=%b addr=%0h data=%0h want 1/1/1a", ok, a, d);
        end
        wait_send(b, ok);
        checks++;
        if (!ok || b !== 8'h1A) begin errors++; $display("FAIL setup_echo: ok=%b got %0h want 1a", ok, b); end
        bus.in_urx = 8'h85; bus.in_urx_vld = 1'b1;
        tick();
        bus.in_urx_vld = 1'b0;
        checks++;
        if (bus.out_err !== 1'b1 || bus.out_busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_ch_err: err=%b busy=%b want 1/0", bus.out_err, bus.out_busy);
        end
        tick();
        checks++;
        if (bus.out_err !== 1'b0 || bus.out_mem_w_en !== 1'b0 || bus.out_busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_ch_after: err=%b w_en=%b busy=%b want 0/0/0",
                     bus.out_err, bus.out_mem_w_en, bus.out_busy);
        end
    endtask

    task automatic test_all_dump();
        logic [7:0] b;
        bit         ok;
        mem[0] = 6'h01; mem[1] = 6'h02; mem[2] = 6'h03; mem[3] = 6'h04;
        bus.in_urx = 8'h7F; bus.in_urx_vld = 1'b1;
        tick();
        bus.in_urx_vld = 1'b0;
        checks++;
        if (bus.out_utx_s_en !== 1'b0 || bus.out_busy !== 1'b1) begin
            errors++;
            $display("FAIL dump_rd: s_en=%b busy=%b want 0/1", bus.out_utx_s_en, bus.out_busy);
        end
        tick();
        checks++;
        if (bus.out_utx_s_en !== 1'b1) begin errors++; $display("FAIL dump_latency: s_en got %b want 1", bus.out_utx_s_en); end
        for (int k = 0; k < 4; k++) begin
            wait_send(b, ok);
            checks++;
            if (!ok || b !== 8'(k + 1)) begin
                errors++;
                $display("FAIL dump_byte%0d: ok=%b got %0h want %0h", k, ok, b, k + 1);
            end
        end
        tick();
        checks++;
        if (bus.out_busy !== 1'b0 || bus.out_utx_s_en !== 1'b0) begin
            errors++;
            $display("FAIL dump_end: busy=%b s_en=%b want 0/0", bus.out_busy, bus.out_utx_s_en);
        end
    endtask

    task automatic test_pending_reset();
        logic [1:0] a;
        logic [5:0] d;
        logic [7:0] b;
        bit         ok;
        bus.in_sw_ch = 2'd0; bus.in_push_sw = 1'b1;
        tick();
        bus.in_push_sw = 1'b0;
        tick();
        bus.in_push_rst = 1'b1;
        tick();
        bus.in_push_rst = 1'b0;
        checks++;
        if (bus.out_rst !== 1'b0) begin errors++; $display("FAIL pend_no_early_rst: got %b want 0", bus.out_rst); end
        wait_write(a, d, ok);
        checks++;
        if (!ok || a !== 2'd0 || d !== 6'h21) begin
            errors++;
            $display("FAIL pend_write: ok=%b addr=%0h data=%0h want 1/0/21", ok, a, d);
        end
        wait_send(b, ok);
        checks++;
        if (!ok || b !== 8'h21) begin errors++; $display("FAIL pend_echo: ok=%b got %0h want 21", ok, b); end
        checks++;
        if (bus.out_rst !== 1'b0 || bus.out_busy !== 1'b0) begin
            errors++;
            $display("FAIL pend_idle: rst=%b busy=%b want 0/0", bus.out_rst, bus.out_busy);
        end
        tick();
        checks++;
        if (bus.out_rst !== 1'b1) begin errors++; $display("FAIL pend_rst_pulse: got %b want 1", bus.out_rst); end
        tick();
        checks++;
        if (bus.out_rst !== 1'b0 || bus.out_busy !== 1'b0) begin
            errors++;
            $display("FAIL pend_rst_width: rst=%b busy=%b want 0/0", bus.out_rst, bus.out_busy);
        end
    endtask

    task automatic test_same_cycle();
        logic [1:0] a;
        logic [5:0] d;
        logic [7:0] b;
        bit         ok;
        bus.in_sw_ch = 2'd3; bus.in_push_sw = 1'b1; bus.in_push_rst = 1'b1;
        tick();
        bus.in_push_sw = 1'b0; bus.in_push_rst = 1'b0;
        checks++;
        if (bus.out_rst !== 1'b0 || bus.out_busy !== 1'b1) begin
            errors++;
            $display("FAIL same_toggle_first: rst=%b busy=%b want 0/1", bus.out_rst, bus.out_busy);
        end
        wait_write(a, d, ok);
        checks++;
        if (!ok || a !== 2'd3 || d !== 6'h24) begin
            errors++;
            $display("FAIL same_write: ok=%b addr=%0h data=%0h want 1/3/24", ok, a, d);
        end
        wait_send(b, ok);
        checks++;
        if (!ok || b !== 8'h24) begin errors++; $display("FAIL same_echo: ok=%b got %0h want 24", ok, b); end
        tick();
        checks++;
        if (bus.out_rst !== 1'b1) begin errors++; $display("FAIL same_rst_after: got %b want 1", bus.out_rst); end
        tick();
    endtask

    task automatic test_reset_mid_send();
        bus.in_utx_s_bs = 1'b1;
        bus.in_urx = 8'h42; bus.in_urx_vld = 1'b1;
        tick();
        bus.in_urx_vld = 1'b0;
        tick();
        checks++;
        if (bus.out_utx_s_en !== 1'b1 || bus.out_utx !== 8'h03) begin
            errors++;
            $display("FAIL midsend_en: s_en=%b utx=%0h want 1/03", bus.out_utx_s_en, bus.out_utx);
        end
        tick();
        tick();
        checks++;
        if (bus.out_utx_s_en !== 1'b1 || bus.out_busy !== 1'b1) begin
            errors++;
            $display("FAIL midsend_hold_busy: s_en=%b busy=%b want 1/1", bus.out_utx_s_en, bus.out_busy);
        end
        bus.in_utx_s_bs = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks += 4;
        if (bus.out_utx_s_en !== 1'b0) begin errors++; $display("FAIL midsend_rst_s_en: got %b want 0", bus.out_utx_s_en); end
        if (bus.out_busy !== 1'b0) begin errors++; $display("FAIL midsend_rst_busy: got %b want 0", bus.out_busy); end
        if (bus.out_utx !== 8'h00) begin errors++; $display("FAIL midsend_rst_utx: got %0h want 0", bus.out_utx); end
        if (bus.out_mem_addr !== 2'd0) begin errors++; $display("FAIL midsend_rst_addr: got %0h want 0", bus.out_mem_addr); end
        tick();
        checks++;
        if (bus.out_busy !== 1'b0 || bus.out_rst !== 1'b0) begin
            errors++;
            $display("FAIL midsend_after: busy=%b rst=%b want 0/0", bus.out_busy, bus.out_rst);
        end
    endtask

    task automatic test_rx_wait();
        bit seen;
        int n;
        bus.in_urx = 8'h80; bus.in_urx_vld = 1'b1;
        tick();
        bus.in_urx_vld = 1'b0;
        seen = 1'b0;
        n = 0;
`ifdef TESTER_FSM_TIMEOUT_EN
        for (int i = 0; i < 40; i++) begin
            if (!seen) begin
                tick();
                n++;
                if (bus.out_err === 1'b1) seen = 1'b1;
            end
        end
        checks++;
        if (!seen || n != 16 || bus.out_busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err: seen=%b cycles=%0d busy=%b want 1/16/0", seen, n, bus.out_busy);
        end
        tick();
        checks++;
        if (bus.out_err !== 1'b0) begin errors++; $display("FAIL timeout_err_width: got %b want 0", bus.out_err); end
`else
        begin
            logic [1:0] a;
            logic [5:0] d;
            logic [7:0] b;
            bit         ok;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (bus.out_err === 1'b1) seen = 1'b1;
            end
            checks++;
            if (seen || bus.out_busy !== 1'b1) begin
                errors++;
                $display("FAIL rx_wait_hold: err_seen=%b busy=%b want 0/1", seen, bus.out_busy);
            end
            bus.in_urx = 8'h21; bus.in_urx_vld = 1'b1;
            tick();
            bus.in_urx_vld = 1'b0;
            wait_write(a, d, ok);
            checks++;
            if (!ok || a !== 2'd0 || d !== 6'h21) begin
                errors++;
                $display("FAIL rx_wait_write: ok=%b addr=%0h data=%0h want 1/0/21", ok, a, d);
            end
            wait_send(b, ok);
            checks++;
            if (!ok || b !== 8'h21) begin errors++; $display("FAIL rx_wait_echo: ok=%b got %0h want 21", ok, b); end
        end
`endif
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.in_push_sw  = 1'b0;
        bus.in_sw_ch    = '0;
        bus.in_push_rst = 1'b0;
        bus.in_urx_vld  = 1'b0;
        bus.in_urx      = '0;
        bus.in_mem_w_rd = 1'b0;
        bus.in_utx_s_bs = 1'b0;
        bus.in_utx_s_rd = 1'b0;
        for (int i = 0; i < 4; i++) mem[i] = '0;
        test_reset();
        test_toggle();
        test_setup();
        test_all_dump();
        test_pending_reset();
        test_same_cycle();
        test_reset_mid_send();
        test_rx_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end
endmodule
